axil_cmd_master: RTL
====================

Name: axil_cmd_master

Overview:
- AXI4-Lite initiator: turns a single-beat command stream into one AXI4-Lite read or write and returns a response.
- Sits in PL in front of the control/status register slaves. Lets PL-side sequencers (bring-up, self-test, sync logic) program and poll registers without the PS.
- Strictly one outstanding transaction, with a bounded-latency timeout so a dead slave cannot hang the sequencer.

Parameters:
- ADDR_WIDTH, 6, AXI address width in bits.
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction from command accept to final AXI handshake; 0 disables the timeout.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  RRESP/BRESP as received; 2'b00 on timeout.
- rsp_timeout  out  1  transaction abandoned by timeout.
- busy  out  1  not IDLE.
- M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, M_AXI_RREADY
  - Standard AXI4-Lite master directions and widths.
  - AWPROT/ARPROT are not driven; the interconnect ties them to 0.

Behaviour:
- Reset values: state IDLE; all *VALID, *READY and rsp_valid = 0; rsp_timeout = 0; busy = 0; registered address/data/strobe = 0; timeout counter = 0. Reset mid-transaction drops everything immediately, with no completion of pending handshakes.
- cmd_ready = (state == IDLE). This is combinational from state only, never from cmd_valid.
- IDLE, on accept:
  - Latch addr, wdata, wstrb.
  - Clear the counter.
  - Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ:
  - AWVALID and WVALID assert on the cycle after accept.
  - AW and W complete independently. aw_done/w_done flags drop each VALID after its own handshake, and each VALID is held stable until then.
  - When both are done (same cycle allowed), go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: capture BRESP, rsp_rdata = 0, go to RSP.
- RD_REQ:
  - ARVALID = 1 until ARREADY, then go to RD_RESP.
- RD_RESP:
  - RREADY = 1.
  - On RVALID: capture RDATA and RRESP, go to RSP.
- RSP:
  - rsp_valid = 1 with fields held stable.
  - On rsp_ready go to IDLE, so the next command is accepted 1 cycle later at the earliest.
- Minimum latency, command accept to rsp_valid:
  - Against a slave with 1-cycle READY and 1-cycle response: write = 4 cycles, read = 4 cycles.
  - Each slave wait cycle adds 1 cycle.
- Timeout (TIMEOUT_CYCLES != 0):
  - The counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - On reaching TIMEOUT_CYCLES-1 without completing: deassert all master VALID/READY that cycle+1, go to RSP with rsp_timeout = 1, rsp_resp = 0, rsp_rdata = 0.
  - A handshake completing on the same cycle the limit is hit wins; there is no timeout in that case.
  - A late BVALID/RVALID from the abandoned transaction is never consumed (READY is 0 in IDLE/RSP). The system treats a timeout as fatal and resets.
- rsp_timeout is cleared when the next command is accepted.
- SLVERR/DECERR are passed through in rsp_resp with rsp_timeout = 0; they are not retried.
- Address and data are not checked for alignment; they are passed through as latched.

Test Plan:
- Write cmd addr=0x04 data=0x00000001 strb=0xF to a 1-cycle slave:
  - AWVALID/WVALID rise together 1 cycle after accept; BREADY seen.
  - rsp_valid 4 cycles after accept, rsp_resp=0, rsp_rdata=0.
- Read addr=0x00 from a slave returning 0xD5170006:
  - ARADDR=0x00 held until ARREADY.
  - rsp_rdata=0xD5170006, rsp_resp=0.
- Write with WREADY 3 cycles after AWREADY:
  - AWVALID drops after its handshake; WVALID is held with stable WDATA until WREADY.
  - BREADY only after both are done.
- TIMEOUT_CYCLES=16, slave never asserts ARREADY:
  - ARVALID drops and rsp_valid=1 with rsp_timeout=1, rsp_rdata=0 exactly 16 cycles after entering RD_REQ.
  - The next read to a good slave clears rsp_timeout.
- Slave returns RRESP=2'b10 data=0xDEADBEEF: rsp_resp=2'b10, rsp_rdata=0xDEADBEEF, rsp_timeout=0.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1: cmd_ready stays 0 and the fields stay stable.
- Assert reset in WR_RESP: all VALID/READY=0 the next cycle, state IDLE, cmd_ready=1 after reset deasserts.

Source files
------------

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns a single-beat command into one AXI4-Lite read or write
// and returns the response. Only one transaction is in flight, and each one has a bounded timeout.
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    busy,

    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    // The counter saturates at TIMEOUT_CYCLES-1, so a stage entered on the limit cycle
    // still times out one cycle later instead of wrapping around.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    timeout_q, timeout_d;

    logic                    limit_hit;
    logic                    abandon;
    logic                    aw_now;
    logic                    w_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        abandon   = 1'b0;
        aw_now    = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
        w_now     = w_done_q | (M_AXI_WVALID & M_AXI_WREADY);
        limit_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX);

        if ((state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (aw_now && w_now) begin
                    state_d = WR_RESP;
                end else if (limit_hit) begin
                    abandon = 1'b1;
                end else begin
                    aw_done_d = aw_now;
                    w_done_d  = w_now;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = RSP;
                end else if (limit_hit) begin
                    abandon = 1'b1;
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    state_d = RD_RESP;
                end else if (limit_hit) begin
                    abandon = 1'b1;
                end
            end
            RD_RESP: begin
                if (M_AXI_RVALID) begin
                    resp_d  = M_AXI_RRESP;
                    rdata_d = M_AXI_RDATA;
                    state_d = RSP;
                end else if (limit_hit) begin
                    abandon = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Leaving the bus stage drops every VALID/READY, so nothing late is ever consumed.
        if (abandon) begin
            state_d   = RSP;
            timeout_d = 1'b1;
            resp_d    = 2'b00;
            rdata_d   = '0;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_timeout   = timeout_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = (state_q == WR_REQ) && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = (state_q == WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = (state_q == RD_REQ);
    assign M_AXI_RREADY  = (state_q == RD_RESP);

endmodule
